// File: rtl/soc_eoc_serial_converter.sv
// soc/eoc responder: after the initiator's request, deserialises W bits from din,
// LSB first, then publishes them on x together with eoc rising.
module soc_eoc_serial_converter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset_,
  input  logic         soc,
  input  logic         din,
  output logic         eoc,
  output logic [W-1:0] x,
  output logic [1:0]   dbg_state
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S0_IDLE    = 2'd0,
    S1_ACK     = 2'd1,
    S2_SHIFT   = 2'd2,
    S3_PUBLISH = 2'd3
  } state_t;

  // Handshake: soc is a level request; eoc=0 acknowledges it and stays low
  // until x is updated, so eoc==1 always comes with fresh x on the same edge.
  state_t          r_state, w_state_next;
  logic [W-1:0]    r_buf, w_buf_next;
  logic [W-1:0]    r_x, w_x_next;
  logic [CW-1:0]   r_count, w_count_next;
  logic            r_eoc, w_eoc_next;

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_state <= S0_IDLE;
      r_buf   <= '0;
      r_x     <= '0;
      r_count <= '0;
      r_eoc   <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_buf   <= w_buf_next;
      r_x     <= w_x_next;
      r_count <= w_count_next;
      r_eoc   <= w_eoc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_buf_next   = r_buf;
    w_x_next     = r_x;
    w_count_next = r_count;
    w_eoc_next   = r_eoc;
    case (r_state)
      S0_IDLE: begin
        if (soc) begin
          w_eoc_next   = 1'b0;
          w_state_next = S1_ACK;
        end
      end
      S1_ACK: begin
        if (!soc) begin
          w_count_next = CW'(W);
          w_state_next = S2_SHIFT;
        end
      end
      S2_SHIFT: begin
        // soc is deliberately ignored here: once shifting starts it always completes.
        w_buf_next   = {din, r_buf[W-1:1]};
        w_count_next = r_count - CW'(1);
        if (r_count == CW'(1)) begin
          w_state_next = S3_PUBLISH;
        end
      end
      S3_PUBLISH: begin
        w_x_next     = r_buf;
        w_eoc_next   = 1'b1;
        w_state_next = S0_IDLE;
      end
      default: begin
        w_state_next = S0_IDLE;
      end
    endcase
  end

  assign eoc       = r_eoc;
  assign x         = r_x;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_soc_eoc_serial_converter.sv
// Bench for soc_eoc_serial_converter: table of directed conversions plus
// hand-written reset sequences; outputs sampled 1ns after each rising edge.
module tb_soc_eoc_serial_converter;

  logic       clock;
  logic       reset_;
  logic       soc;
  logic       din;
  logic       eoc;
  logic [7:0] x;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [7:0] held_x;

  typedef struct {
    string      name;
    logic [7:0] din_bits;   // bit i is driven on the i-th shift clock
    int         hold;       // extra clocks soc stays high after eoc falls
    bit         pulse;      // toggle soc in the middle of the shift phase
    logic [7:0] exp_x;
    int         idle_after;
  } vec_t;

  vec_t vecs[5];

  soc_eoc_serial_converter #(.W(8)) dut (
    .clock     (clock),
    .reset_    (reset_),
    .soc       (soc),
    .din       (din),
    .eoc       (eoc),
    .x         (x),
    .dbg_state (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_conv(input vec_t v);
    soc = 1'b1;
    tick();
    check({v.name, "_ack_eoc"}, eoc, 0);
    check({v.name, "_ack_state"}, dbg_state, 1);
    check({v.name, "_ack_x_held"}, x, held_x);
    for (int h = 0; h < v.hold; h++) begin
      din = ~din;
      tick();
      check({v.name, "_hold_state"}, dbg_state, 1);
      check({v.name, "_hold_eoc"}, eoc, 0);
    end
    soc = 1'b0;
    tick();
    check({v.name, "_e0_state"}, dbg_state, 2);
    for (int i = 0; i < 8; i++) begin
      din = v.din_bits[i];
      if (v.pulse && i == 3) soc = 1'b1;
      if (v.pulse && i == 5) soc = 1'b0;
      tick();
      check({v.name, "_shift_eoc"}, eoc, 0);
      check({v.name, "_shift_x_held"}, x, held_x);
    end
    check({v.name, "_e8_state"}, dbg_state, 3);
    din = 1'b0;
    tick();
    check({v.name, "_done_eoc"}, eoc, 1);
    check({v.name, "_done_x"}, x, v.exp_x);
    check({v.name, "_done_state"}, dbg_state, 0);
    held_x = v.exp_x;
    for (int k = 0; k < v.idle_after; k++) begin
      din = 1'($urandom_range(0, 1));
      tick();
      check({v.name, "_idle_eoc"}, eoc, 1);
      check({v.name, "_idle_x"}, x, held_x);
      check({v.name, "_idle_state"}, dbg_state, 0);
    end
  endtask

  initial begin
    vecs[0] = '{"single",    8'h4D, 0,  1'b0, 8'h4D, 3};
    vecs[1] = '{"slow",      8'hFF, 10, 1'b0, 8'hFF, 3};
    vecs[2] = '{"b2b_a",     8'hA5, 0,  1'b0, 8'hA5, 20};
    vecs[3] = '{"b2b_b",     8'h3C, 0,  1'b0, 8'h3C, 3};
    vecs[4] = '{"violation", 8'hC6, 0,  1'b1, 8'hC6, 5};

    reset_ = 1'b0;
    soc    = 1'b0;
    din    = 1'b0;
    held_x = 8'h00;
    for (int c = 0; c < 2; c++) begin
      soc = 1'($urandom_range(0, 1));
      din = 1'($urandom_range(0, 1));
      tick();
    end
    check("reset_eoc", eoc, 1);
    check("reset_x", x, 8'h00);
    check("reset_state", dbg_state, 0);
    soc = 1'b0;
    din = 1'b0;
    reset_ = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("post_reset_eoc", eoc, 1);
      check("post_reset_state", dbg_state, 0);
    end

    for (int n = 0; n < 5; n++) begin
      run_conv(vecs[n]);
    end

    // Abort a conversion after four shifted bits with an asynchronous reset.
    soc = 1'b1;
    tick();
    soc = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      din = 1'b1;
      tick();
    end
    check("midrst_pre_state", dbg_state, 2);
    #2;
    reset_ = 1'b0;
    #1;
    check("midrst_async_eoc", eoc, 1);
    check("midrst_async_x", x, 8'h00);
    check("midrst_async_state", dbg_state, 0);
    held_x = 8'h00;
    tick();
    tick();
    reset_ = 1'b1;
    din = 1'b0;
    tick();
    check("midrst_after_eoc", eoc, 1);
    check("midrst_after_x", x, 8'h00);
    run_conv('{"after_rst", 8'h81, 0, 1'b0, 8'h81, 2});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/soc_eoc_serial_converter.md
Name: soc_eoc_serial_converter

Overview:
- Responder end of the soc/eoc start-of-conversion handshake: it supplies a W-bit byte on x to an initiator that drives soc and reads x once eoc returns high.
- Each conversion deserialises W bits from the serial line din, LSB first, one bit per clock.
- Sits between a serial source (sensor or link) and any soc/eoc consumer; it replaces a behavioural converter model in the exercise benches.

Parameters:
- W, 8, data width: bits per conversion, and the width of x.

Ports:
- clock  in  1  system clock, all activity on posedge.
- reset_  in  1  asynchronous reset, active low.
- soc  in  1  start of conversion from the initiator, level-sensitive.
- din  in  1  serial data line, sampled on posedge during conversion.
- eoc  out  1  end of conversion: 1 = idle or data valid, 0 = conversion in progress.
- x  out  W  converted data; stable whenever eoc==1.

Behaviour:
- Reset (reset_==0, asynchronous, wins over clock): eoc=1, x=0, internal buffer=0, COUNT=0, state=S0. A reset mid-conversion aborts it; no partial data reaches x.
- Handshake (initiator side, fixed):
  - Initiator raises soc.
  - Responder answers eoc=0.
  - Initiator drops soc.
  - Responder converts, then raises eoc with x valid.
  - Initiator reads x while eoc==1.
- S0 IDLE: eoc=1, x held.
  - soc==1 at a posedge: eoc<=0, go to S1.
  - soc==0: stay in S0.
- S1 ACK: eoc=0.
  - soc==0 at a posedge: COUNT<=W, go to S2.
  - soc==1: stay in S1. There is no timeout.
- S2 SHIFT: eoc=0.
  - Every posedge: BUFFER<={din, BUFFER[W-1:1]}, COUNT<=COUNT-1.
  - COUNT==1 at the edge: go to S3.
  - Exactly W samples are taken. The first din sample becomes x[0]; the W-th sample becomes x[W-1].
- S3 PUBLISH: x<=BUFFER, eoc<=1, go to S0. x and eoc change on the same edge, so the initiator never sees eoc==1 with stale x.
- Latency: the edge that first samples soc==0 in S1 is E0. Bits are sampled at E1..EW. x and eoc=1 appear at E(W+1), i.e. W+1 clocks after soc is seen low.
- Protocol violations:
  - soc toggling during S2 or S3 is ignored. The conversion completes and eoc rises regardless.
  - soc still 1 when S0 is re-entered starts a new conversion on the next edge; the previous x stays visible until the next S3.
- x changes only in S3 and at reset. eoc changes only on the S0->S1 edge, the S3 edge, and at reset.
- Back-to-back conversions: the minimum cycle is S0 to S0 = W+3 clocks (S0, S1, W x S2, S3) with an ideal initiator.
- Widths: COUNT needs ceil(log2(W+1)) bits. The state register is 2 bits. No arithmetic beyond the COUNT decrement.

Test Plan:
- Reset: reset_=0 for 2 clocks with random soc/din -> eoc=1, x=8'h00, state S0; soc=0 afterwards keeps eoc=1 indefinitely.
- Single conversion: soc=1 -> eoc=0 on the next edge; then soc=0, din serial sequence 1,0,1,1,0,0,1,0 -> x=8'h4D with eoc=1 exactly 9 clocks after soc is sampled low.
- Slow initiator: hold soc=1 for 10 clocks after eoc falls -> eoc stays 0, no shifting; after soc=0, din all 1s -> x=8'hFF.
- Back-to-back: initiator model with 20-clock idle between requests, din patterns 8'hA5 then 8'h3C -> x=8'hA5, held through the gap, then 8'h3C; eoc low only during conversions.
- Violation: soc pulsed to 1 in the middle of S2 -> conversion completes on schedule with the correct byte; no extra conversion starts until S0 sees soc=1.
- Reset mid-conversion: reset_=0 after 4 shifted bits -> eoc=1 and x=0 immediately (asynchronous); next full conversion with 8'h81 -> x=8'h81.
